// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared types and constants for the pattern scan controller.
//   state_e     - controller FSM states (IDLE, LOAD, SHIFT, FLUSH, DONE)
//   det_state_e - states of the serial 10010 Moore detector (S0..S5)
//   PATTERN     - the bit pattern searched for, MSB first
//   PAT_LEN     - pattern length in bits
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        FLUSH,
        DONE
    } state_e;

    localparam logic [4:0]  PATTERN = 5'b10010;
    localparam int unsigned PAT_LEN = 5;

    // Sn = longest pattern prefix of length n matched so far; S5 = full match
    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4,
        S5
    } det_state_e;

endpackage

// File: rtl/seq10010_det.sv
// seq10010_det: 6-state Moore detector for the serial pattern 10010,
// overlapping matches allowed.
//   clk - clock, rising edge
//   rst - synchronous active-high reset to S0
//   clr - synchronous clear to S0 (start of a new word)
//   j   - serial input bit
//   w   - high while the detector sits in the full-match state
module seq10010_det
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic j,
    output logic w
);

    det_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // On a mismatch fall back to the longest suffix that is still a prefix
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      state_d = j ? S1 : S0;
            S1:      state_d = j ? S1 : S2;
            S2:      state_d = j ? S1 : S3;
            S3:      state_d = j ? S4 : S0;
            S4:      state_d = j ? S1 : S5;
            S5:      state_d = j ? S1 : S3;
            default: state_d = S0;
        endcase
    end

    assign w = (state_q == S5);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: round-robin scheduler that serialises one requester's
// word MSB-first through a shared 10010 detector and reports the number of
// overlapping matches.
//   clk, rst   - clock and synchronous active-high reset
//   req        - per-requester request, held with its data until granted
//   data_in    - word for requester i at [i*WIDTH +: WIDTH]
//   grant      - one-hot, single cycle, word captured in that cycle
//   busy       - high from the grant cycle through the done cycle
//   done       - single-cycle result strobe
//   done_id    - requester served, held until the next done
//   match_cnt  - saturating match count, held until the next done
// Optional macro FIRST_POS_EN adds:
//   found      - at least one match in the word
//   first_pos  - bit index (0 = MSB) of the final bit of the first match
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1),
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [CNTW-1:0]         match_cnt
`ifdef FIRST_POS_EN
    ,
    output logic                    found,
    output logic [$clog2(WIDTH)-1:0] first_pos
`endif
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    win_q, win_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CNTW-1:0]   bitcnt_q, bitcnt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]    done_id_q, done_id_d;
    logic [CNTW-1:0]   match_cnt_q, match_cnt_d;
    logic [CNTW-1:0]   cnt_inc;
    logic [IDW-1:0]    pick;
    logic [IDW:0]      idx;
    logic              any_req;
    logic              det_clr;
    logic              det_w;

`ifdef FIRST_POS_EN
    localparam int unsigned POSW = $clog2(WIDTH);
    logic              hit_q, hit_d;
    logic [POSW-1:0]   pos_q, pos_d;
    logic              found_q, found_d;
    logic [POSW-1:0]   first_pos_q, first_pos_d;
    logic [POSW-1:0]   pos_now;

    // w seen now reflects the bit shifted in during the previous cycle
    assign pos_now = POSW'(bitcnt_q - 1'b1);
`endif

    seq10010_det u_det (
        .clk (clk),
        .rst (rst),
        .clr (det_clr),
        .j   (sreg_q[WIDTH-1]),
        .w   (det_w)
    );

    assign cnt_inc = (det_w && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    // Round-robin search starting at the pointer, wrapping at NREQ
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_q} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(NREQ)) begin
                idx = idx - (IDW + 1)'(NREQ);
            end
            if (!any_req && req[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                pick    = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            sreg_q      <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
`ifdef FIRST_POS_EN
            hit_q       <= 1'b0;
            pos_q       <= '0;
            found_q     <= 1'b0;
            first_pos_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            sreg_q      <= sreg_d;
            bitcnt_q    <= bitcnt_d;
            cnt_q       <= cnt_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
`ifdef FIRST_POS_EN
            hit_q       <= hit_d;
            pos_q       <= pos_d;
            found_q     <= found_d;
            first_pos_q <= first_pos_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        sreg_d      = sreg_q;
        bitcnt_d    = bitcnt_q;
        cnt_d       = cnt_q;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        grant       = '0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        det_clr     = 1'b0;
`ifdef FIRST_POS_EN
        hit_d       = hit_q;
        pos_d       = pos_q;
        found_d     = found_q;
        first_pos_d = first_pos_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d   = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                grant[win_q] = 1'b1;
                sreg_d       = data_in[win_q*WIDTH +: WIDTH];
                det_clr      = 1'b1;
                cnt_d        = '0;
                bitcnt_d     = '0;
                rr_d         = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef FIRST_POS_EN
                hit_d        = 1'b0;
                pos_d        = '0;
`endif
                state_d      = SHIFT;
            end
            SHIFT: begin
                sreg_d   = sreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                // First SHIFT cycle still shows the cleared detector
                if (bitcnt_q != '0) begin
                    cnt_d = cnt_inc;
`ifdef FIRST_POS_EN
                    if (det_w && !hit_q) begin
                        hit_d = 1'b1;
                        pos_d = pos_now;
                    end
`endif
                end
                if (bitcnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Results are registered here so they are valid alongside done
                cnt_d       = cnt_inc;
                match_cnt_d = cnt_inc;
                done_id_d   = win_q;
`ifdef FIRST_POS_EN
                found_d     = hit_q || det_w;
                first_pos_d = hit_q ? pos_q : (det_w ? pos_now : '0);
`endif
                state_d     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
`ifdef FIRST_POS_EN
    assign found     = found_q;
    assign first_pos = first_pos_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and randomized checks of pattern_scan_ctrl
// against a word-level reference model (pattern search by sliding window,
// round-robin pointer kept as an integer).
module tb_pattern_scan_ctrl;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNTW  = $clog2(WIDTH + 1);
    localparam int unsigned IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CNTW-1:0]       match_cnt;
`ifdef FIRST_POS_EN
    logic                  found;
    logic [$clog2(WIDTH)-1:0] first_pos;
`endif

    logic [WIDTH-1:0] words [NREQ];
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int ptr_m = 0;
    int last_grant_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = words[i];
    end

    pattern_scan_ctrl #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
`ifdef FIRST_POS_EN
        ,
        .found     (found),
        .first_pos (first_pos)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    // Slide a 5-bit window from the MSB; overlapping windows all count
    task automatic ref_scan(input logic [WIDTH-1:0] w, output int cnt, output int fp);
        logic [4:0] pat;
        logic [4:0] win;
        pat = 5'b10010;
        cnt = 0;
        fp  = -1;
        for (int i = 0; i + 5 <= WIDTH; i++) begin
            win = w[WIDTH-1-i -: 5];
            if (win == pat) begin
                if (fp < 0) fp = i + 4;
                if (cnt < (1 << CNTW) - 1) cnt++;
            end
        end
    endtask

    task automatic run_txn(input string tag, input bit drop);
        int exp_id, exp_cnt, exp_fp, g_cyc;
        bit seen, saw_done;
        exp_id = ref_winner(req, ptr_m);
        ref_scan(words[exp_id], exp_cnt, exp_fp);
        seen = 0;
        saw_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (grant != '0) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_grant_seen"}, 32'(seen), 32'd1);
        chk({tag, "_no_early_done"}, 32'(saw_done), 32'd0);
        if (!seen) return;
        g_cyc = cyc;
        last_grant_cyc = g_cyc;
        chk({tag, "_grant"}, 32'(grant), 32'd1 << exp_id);
        chk({tag, "_busy_grant"}, 32'(busy), 32'd1);
        if (drop) req[exp_id] = 1'b0;
        ptr_m = (exp_id + 1) % NREQ;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({tag, "_latency"}, 32'(cyc - g_cyc), 32'(WIDTH + 2));
        chk({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
        chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
`ifdef FIRST_POS_EN
        chk({tag, "_found"}, 32'(found), (exp_fp >= 0) ? 32'd1 : 32'd0);
        chk({tag, "_first_pos"}, 32'(first_pos), (exp_fp >= 0) ? 32'(exp_fp) : 32'd0);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_id_held"}, 32'(done_id), 32'(exp_id));
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int prev;
        bit seen, saw_done;
        for (int i = 0; i < NREQ; i++) words[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);

        // All requesters held: order 0,1,2,3,0 with WIDTH+4 spacing
        for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
        req = '1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            run_txn("rr_all", 1'b0);
            chk("rr_order", 32'(done_id), 32'(k % NREQ));
            if (k > 0) chk("rr_spacing", 32'(last_grant_cyc - prev), 32'(WIDTH + 4));
            prev = last_grant_cyc;
        end
        req = '0;

        // Directed words on requester 0
        words[0] = 16'h9249; req = 4'b0001; run_txn("w9249", 1'b1);
        chk("w9249_cnt_const", 32'(match_cnt), 32'd4);
        words[0] = 16'h0012; req = 4'b0001; run_txn("w0012", 1'b1);
        chk("w0012_cnt_const", 32'(match_cnt), 32'd1);
        words[0] = 16'h0000; req = 4'b0001; run_txn("w0000", 1'b1);
        words[0] = 16'hFFFF; req = 4'b0001; run_txn("wFFFF", 1'b1);

        // Word A ends in 1001, word B of zeros must not complete a match
        words[0] = 16'hA009; req = 4'b0001; run_txn("xword_a", 1'b1);
        words[0] = 16'h0000; req = 4'b0001; run_txn("xword_b", 1'b1);
        chk("xword_b_cnt_const", 32'(match_cnt), 32'd0);

        // Reset in the 8th SHIFT cycle aborts the word
        words[1] = 16'h9249; words[2] = 16'h4924; req = 4'b0110;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (grant != '0) begin
                seen = 1;
                break;
            end
        end
        chk("abort_grant_seen", 32'(seen), 32'd1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        chk("abort_match_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0;
        ptr_m = 0;
        run_txn("after_rst", 1'b1);
        chk("after_rst_id_const", 32'(done_id), 32'd1);
        req = '0;

        // Pointer wraps from 3 to 0
        words[3] = 16'h1248; req = 4'b1000; run_txn("wrap_a", 1'b1);
        words[0] = 16'h2492; req = 4'b1001; run_txn("wrap_b", 1'b1);
        chk("wrap_b_id_const", 32'(done_id), 32'd0);
        req = '0;

        // Randomized traffic; pending requests keep their words
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1) words[i] = WIDTH'($urandom);
                    else words[i] = (16'h9249 >> $urandom_range(0, 3)) ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                req[0] = 1'b1;
                words[0] = WIDTH'($urandom);
            end
            run_txn("rand", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
